// File: rtl/jzjpcc_fetch.sv
// Fetch stage for the jzjpcc pipeline: drives a 1-cycle-latency instruction memory
// and tracks the PC/valid of the instruction sitting in the decode slot.
module jzjpcc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_decode,
    input  logic        redirect_execute,
    input  logic [31:0] redirectTarget_execute,
    input  logic        haltRequest_execute,
    output logic [29:0] instAddress_fetch,
    output logic        instReadEnable_fetch,
    output logic [31:0] pc_decode,
    output logic        valid_decode,
    output logic        halted_fetch,
    output logic        misalignedFetch,
    output logic [31:0] faultPc,
    output logic [31:0] instCount_fetch
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] fetch_pc;
    logic        misaligned_redirect;
    logic        halt_now;

    assign misaligned_redirect = redirect_execute && (redirectTarget_execute[1:0] != 2'b00);
    assign halt_now            = haltRequest_execute || misaligned_redirect;
    assign instAddress_fetch   = fetch_pc[31:2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (state == RUN && halt_now) begin
            next_state = HALTED;
        end
    end

    // The memory must already be reading RESET_PC during reset so the first
    // edge after release delivers it; a redirect overrides any stall.
    always_comb begin
        instReadEnable_fetch = 1'b0;
        if (reset) begin
            instReadEnable_fetch = 1'b1;
        end else if (state == RUN) begin
            instReadEnable_fetch = redirect_execute || !stall_decode;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc        <= RESET_PC;
            pc_decode       <= 32'h0;
            valid_decode    <= 1'b0;
            halted_fetch    <= 1'b0;
            misalignedFetch <= 1'b0;
            faultPc         <= 32'h0;
            instCount_fetch <= 32'h0;
        end else begin
            halted_fetch <= (next_state == HALTED);
            if (state == RUN) begin
                // Misaligned redirect wins over a simultaneous halt so the fault is recorded.
                if (misaligned_redirect) begin
                    misalignedFetch <= 1'b1;
                    faultPc         <= redirectTarget_execute;
                    valid_decode    <= 1'b0;
                end else if (haltRequest_execute) begin
                    valid_decode <= 1'b0;
                end else if (redirect_execute) begin
                    fetch_pc     <= redirectTarget_execute;
                    valid_decode <= 1'b0;
                end else if (!stall_decode) begin
                    pc_decode       <= fetch_pc;
                    valid_decode    <= 1'b1;
                    fetch_pc        <= fetch_pc + 32'd4;
                    instCount_fetch <= instCount_fetch + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jzjpcc_fetch.sv
// Self-checking bench for jzjpcc_fetch: a reference model pushes expected decode-slot
// state into a scoreboard queue each cycle, popped and compared after the edge.
module tb_jzjpcc_fetch;

    logic        clock;
    logic        reset;
    logic        stall_decode;
    logic        redirect_execute;
    logic [31:0] redirectTarget_execute;
    logic        haltRequest_execute;

    logic [29:0] instAddress_fetch;
    logic        instReadEnable_fetch;
    logic [31:0] pc_decode;
    logic        valid_decode;
    logic        halted_fetch;
    logic        misalignedFetch;
    logic [31:0] faultPc;
    logic [31:0] instCount_fetch;

    logic [29:0] wrap_inst_address;
    logic        wrap_read_enable;
    logic [31:0] wrap_pc_decode;
    logic        wrap_valid;
    logic        wrap_halted;
    logic        wrap_misaligned;
    logic [31:0] wrap_fault_pc;
    logic [31:0] wrap_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pcd;
        logic        valid;
        logic [29:0] addr;
        logic [31:0] count;
        logic        halted;
        logic        mis;
        logic [31:0] fault;
    } exp_t;

    exp_t sb_queue[$];

    logic [31:0] m_fetch, m_pcd, m_count, m_fault;
    logic        m_valid, m_halted, m_mis;

    jzjpcc_fetch #(.RESET_PC(32'h00000000)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .stall_decode          (stall_decode),
        .redirect_execute      (redirect_execute),
        .redirectTarget_execute(redirectTarget_execute),
        .haltRequest_execute   (haltRequest_execute),
        .instAddress_fetch     (instAddress_fetch),
        .instReadEnable_fetch  (instReadEnable_fetch),
        .pc_decode             (pc_decode),
        .valid_decode          (valid_decode),
        .halted_fetch          (halted_fetch),
        .misalignedFetch       (misalignedFetch),
        .faultPc               (faultPc),
        .instCount_fetch       (instCount_fetch)
    );

    jzjpcc_fetch #(.RESET_PC(32'hFFFFFFF8)) dut_wrap (
        .clock                 (clock),
        .reset                 (reset),
        .stall_decode          (stall_decode),
        .redirect_execute      (redirect_execute),
        .redirectTarget_execute(redirectTarget_execute),
        .haltRequest_execute   (haltRequest_execute),
        .instAddress_fetch     (wrap_inst_address),
        .instReadEnable_fetch  (wrap_read_enable),
        .pc_decode             (wrap_pc_decode),
        .valid_decode          (wrap_valid),
        .halted_fetch          (wrap_halted),
        .misalignedFetch       (wrap_misaligned),
        .faultPc               (wrap_fault_pc),
        .instCount_fetch       (wrap_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_fetch  = 32'h0;
        m_pcd    = 32'h0;
        m_count  = 32'h0;
        m_fault  = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
    endtask

    // Behavioural model of one clock edge: halt/misaligned > redirect > stall > advance.
    task automatic modelStep(input logic stall, input logic redir, input logic [31:0] tgt, input logic halt);
        if (!m_halted) begin
            if (redir && tgt[1:0] != 2'b00) begin
                m_mis    = 1'b1;
                m_fault  = tgt;
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else if (halt) begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else if (redir) begin
                m_fetch = tgt;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_pcd   = m_fetch;
                m_valid = 1'b1;
                m_fetch = m_fetch + 32'd4;
                m_count = m_count + 32'd1;
            end
        end
    endtask

    task automatic compareScoreboard();
        exp_t e;
        if (sb_queue.size() == 0) begin
            checkOutput("sbEmpty", 64'd0, 64'd1);
        end else begin
            e = sb_queue.pop_front();
            checkOutput("pc_decode", pc_decode, e.pcd);
            checkOutput("valid_decode", valid_decode, e.valid);
            checkOutput("instAddress", instAddress_fetch, e.addr);
            checkOutput("instCount", instCount_fetch, e.count);
            checkOutput("halted", halted_fetch, e.halted);
            checkOutput("misaligned", misalignedFetch, e.mis);
            checkOutput("faultPc", faultPc, e.fault);
        end
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic applyStimulus(input logic stall, input logic redir, input logic [31:0] tgt, input logic halt);
        exp_t e;
        logic halting;
        stall_decode           = stall;
        redirect_execute       = redir;
        redirectTarget_execute = tgt;
        haltRequest_execute    = halt;
        #1;
        halting = halt || (redir && tgt[1:0] != 2'b00);
        if (m_halted || !halting) begin
            checkOutput("readEnable", instReadEnable_fetch, m_halted ? 1'b0 : (redir || !stall));
        end
        modelStep(stall, redir, tgt, halt);
        e.pcd    = m_pcd;
        e.valid  = m_valid;
        e.addr   = m_fetch[31:2];
        e.count  = m_count;
        e.halted = m_halted;
        e.mis    = m_mis;
        e.fault  = m_fault;
        sb_queue.push_back(e);
        @(posedge clock);
        #1;
        compareScoreboard();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pcd"}, pc_decode, 32'h0);
        checkOutput({tag, "_valid"}, valid_decode, 1'b0);
        checkOutput({tag, "_count"}, instCount_fetch, 32'h0);
        checkOutput({tag, "_halted"}, halted_fetch, 1'b0);
        checkOutput({tag, "_mis"}, misalignedFetch, 1'b0);
        checkOutput({tag, "_fault"}, faultPc, 32'h0);
        checkOutput({tag, "_re"}, instReadEnable_fetch, 1'b1);
        checkOutput({tag, "_addr"}, instAddress_fetch, 30'h0);
    endtask

    initial begin
        logic [31:0] held_addr;
        reset                  = 1'b1;
        stall_decode           = 1'b1;
        redirect_execute       = 1'b0;
        redirectTarget_execute = 32'h0;
        haltRequest_execute    = 1'b0;
        modelReset();

        repeat (2) @(posedge clock);
        #1;
        checkResetValues("reset");
        checkOutput("wrapResetAddr", wrap_inst_address, 30'h3FFFFFFE);

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("firstPc", pc_decode, 32'h0);
        checkOutput("wrapPc0", wrap_pc_decode, 32'hFFFFFFF8);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("secondPc", pc_decode, 32'h4);
        checkOutput("wrapPc1", wrap_pc_decode, 32'hFFFFFFFC);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("thirdPc", pc_decode, 32'h8);
        checkOutput("thirdAddr", instAddress_fetch, 30'h3);
        checkOutput("thirdCount", instCount_fetch, 32'd3);
        checkOutput("wrapPc2", wrap_pc_decode, 32'h00000000);
        checkOutput("wrapValid", wrap_valid, 1'b1);

        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("stallPc", pc_decode, 32'h8);
        checkOutput("stallCount", instCount_fetch, 32'd3);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("afterStallPc", pc_decode, 32'hC);

        applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
        checkOutput("redirFlush", valid_decode, 1'b0);
        checkOutput("redirAddr", instAddress_fetch, 30'h40);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("redirTargetPc", pc_decode, 32'h100);
        checkOutput("redirTargetValid", valid_decode, 1'b1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 32'h2000, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        held_addr = {m_fetch[31:2], 2'b00};
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
        checkOutput("haltRedirHalted", halted_fetch, 1'b1);
        checkOutput("haltRedirMis", misalignedFetch, 1'b0);
        checkOutput("haltRedirAddr", instAddress_fetch, held_addr[31:2]);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, $urandom() | 32'h1, 1'($urandom_range(0, 1)));
        end
        checkOutput("haltedIgnoresMis", misalignedFetch, 1'b0);

        #2;
        reset = 1'b1;
        #1;
        checkResetValues("asyncReset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        sb_queue.delete();

        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h102, 1'b0);
        checkOutput("misHalted", halted_fetch, 1'b1);
        checkOutput("misFlag", misalignedFetch, 1'b1);
        checkOutput("misFault", faultPc, 32'h102);
        checkOutput("misValid", valid_decode, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
        end
        checkOutput("misFaultHeld", faultPc, 32'h102);
        checkOutput("misCountHeld", instCount_fetch, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
